// File: rtl/bmf_h_decoder.sv
// bmf_h_decoder: rebuilds M-bit words as the Boolean product k x H.
// Define BMF_XOR_EN to accumulate with XOR (GF(2)) instead of OR.
module bmf_h_decoder #(
  parameter int K = 3,
  parameter int M = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_we,
  input  logic [((K > 1) ? $clog2(K) : 1)-1:0] cfg_row,
  input  logic [M-1:0]                         cfg_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [K-1:0]                         in_k,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [M-1:0]                         out_data,
  output logic                                 busy
);

  localparam int RW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [M-1:0]  h [K];
  logic [K-1:0]  kreg;
  logic [RW-1:0] idx;
  logic [M-1:0]  acc;
  logic [M-1:0]  acc_op;
  logic [M-1:0]  row;
  logic          bit_sel;
  logic          last;
  logic          accept;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == RW'(K - 1));

  // Row mux keeps idx values beyond K-1 from indexing H directly.
  always_comb begin
    row     = '0;
    bit_sel = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (idx == RW'(i)) begin
        row     = h[i];
        bit_sel = kreg[i];
      end
    end
  end

`ifdef BMF_XOR_EN
  assign acc_op = acc ^ row;
`else
  assign acc_op = acc | row;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = ACCUM;
      ACCUM:   if (last) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kreg <= '0;
      idx  <= '0;
      acc  <= '0;
    end else if (accept) begin
      kreg <= in_k;
      idx  <= '0;
      acc  <= '0;
    end else if (state == ACCUM) begin
      if (bit_sel) acc <= acc_op;
      idx <= idx + 1'b1;
    end
  end

  // Out-of-range rows match no index and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) h[i] <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < K; i++) begin
        if (cfg_row == RW'(i)) h[i] <= cfg_data;
      end
    end
  end

endmodule
